// File: rtl/ram_ctrl.sv
// Memory sequencer between MAR/MDR and a byte-wide RAM: latches one request,
// waits WAIT cycles, performs the access, then pulses rdy for one cycle.
module ram_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int WAIT   = 2
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  input  logic              nRd,
  input  logic              nWr,
  output logic [7:0]        dout,
  output logic              busy,
  output logic              rdy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic              op_q;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        mem [DEPTH];

  // DEPTH need not be a power of two, so wrap with a true modulo; the extra
  // bit lets DEPTH = 2^ADDR_W be represented without overflowing to zero.
  assign idx = IDX_W'({1'b0, addr_q} % MW'(DEPTH));

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      din_q  <= '0;
      op_q   <= 1'b0;
      dout   <= 8'h00;
      busy   <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b0;
          if (!nWr || !nRd) begin
            addr_q <= addr;
            din_q  <= din;
            op_q   <= !nWr;
            cnt    <= 4'(WAIT);
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_q) dout <= mem[idx];
            busy  <= 1'b0;
            rdy   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          rdy   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          rdy   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; an access dropped by nCLR never reaches this commit.
  always_ff @(posedge CLK) begin
    if (state == BUSY && cnt == 4'd0 && op_q) mem[idx] <= din_q;
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: table of accesses checked by a rdy-driven
// scoreboard, plus hand sequences for ignored strobes, reset and back-to-back.
module tb_ram_ctrl;

  localparam int WAIT_T = 2;

  logic        CLK = 1'b0;
  logic        nCLR;
  logic [15:0] addr, addr2;
  logic [7:0]  din, din2;
  logic        nRd, nWr, nRd2, nWr2;
  logic [7:0]  dout, dout2;
  logic        busy, rdy, busy2, rdy2;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  typedef struct {
    bit          is_rd;
    logic [7:0]  data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_dout;
  } vec_t;
  vec_t vecs[12];

  ram_ctrl #(.ADDR_W(16), .DEPTH(256), .WAIT(WAIT_T)) dut (
    .CLK(CLK), .nCLR(nCLR), .addr(addr), .din(din), .nRd(nRd), .nWr(nWr),
    .dout(dout), .busy(busy), .rdy(rdy)
  );

  ram_ctrl #(.ADDR_W(16), .DEPTH(200), .WAIT(0)) dut2 (
    .CLK(CLK), .nCLR(nCLR), .addr(addr2), .din(din2), .nRd(nRd2), .nWr(nWr2),
    .dout(dout2), .busy(busy2), .rdy(rdy2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Every rdy pulse must match the oldest outstanding access in time and data.
  always @(posedge CLK) begin
    #1;
    if (nCLR === 1'b1 && rdy === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_rdy: got rdy=1 at cycle %0d, required no pending access", cycle);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rdy_cycle", cycle, mon_e.due);
        checkOutput(mon_e.is_rd ? "rd_dout" : "wr_dout_hold", {24'h0, dout}, {24'h0, mon_e.data});
      end
    end
  end

  task automatic applyStimulus(input bit wr, input bit rd, input logic [15:0] a,
                               input logic [7:0] d, input logic [7:0] exp_dout);
    int n;
    addr = a;
    din  = d;
    nWr  = !wr;
    nRd  = !rd;
    if (wr || rd) sb.push_back('{is_rd: !wr, data: exp_dout, due: cycle + WAIT_T + 2});
    @(posedge CLK); #1;
    nWr = 1'b1;
    nRd = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge CLK); #1;
    end
    checkOutput("busy_len", n, WAIT_T + 1);
    @(posedge CLK); #1;
    checkOutput("rdy_width", {31'h0, rdy}, 32'h0);
  endtask

  task automatic op2(input bit wr, input logic [15:0] a, input logic [7:0] d,
                     output logic [7:0] rd_val, output int nbusy, output logic got_rdy);
    addr2 = a;
    din2  = d;
    nWr2  = !wr;
    nRd2  = wr;
    @(posedge CLK); #1;
    nWr2  = 1'b1;
    nRd2  = 1'b1;
    nbusy = 0;
    while (busy2 === 1'b1 && nbusy < 40) begin
      nbusy++;
      @(posedge CLK); #1;
    end
    got_rdy = rdy2;
    rd_val  = dout2;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [7:0] v2;
    int         nb2;
    logic       r2;
    int         guard;

    vecs[0]  = '{wr: 1, rd: 0, a: 16'h0010, d: 8'hA5, exp_dout: 8'h00};
    vecs[1]  = '{wr: 0, rd: 1, a: 16'h0010, d: 8'h00, exp_dout: 8'hA5};
    vecs[2]  = '{wr: 1, rd: 1, a: 16'h0020, d: 8'h3C, exp_dout: 8'hA5};
    vecs[3]  = '{wr: 0, rd: 1, a: 16'h0020, d: 8'hEE, exp_dout: 8'h3C};
    vecs[4]  = '{wr: 1, rd: 0, a: 16'h0105, d: 8'h77, exp_dout: 8'h3C};
    vecs[5]  = '{wr: 0, rd: 1, a: 16'h0005, d: 8'h00, exp_dout: 8'h77};
    vecs[6]  = '{wr: 0, rd: 1, a: 16'h0105, d: 8'h00, exp_dout: 8'h77};
    vecs[7]  = '{wr: 1, rd: 0, a: 16'h0030, d: 8'h00, exp_dout: 8'h77};
    vecs[8]  = '{wr: 1, rd: 0, a: 16'h0040, d: 8'h00, exp_dout: 8'h77};
    vecs[9]  = '{wr: 1, rd: 0, a: 16'h01FF, d: 8'h5A, exp_dout: 8'h77};
    vecs[10] = '{wr: 0, rd: 1, a: 16'h00FF, d: 8'h00, exp_dout: 8'h5A};
    vecs[11] = '{wr: 0, rd: 1, a: 16'h0010, d: 8'h00, exp_dout: 8'hA5};

    nCLR = 1'b0;
    addr = '0;  din = '0;  nRd = 1'b1; nWr = 1'b1;
    addr2 = '0; din2 = '0; nRd2 = 1'b1; nWr2 = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    nCLR = 1'b1;
    checkOutput("reset_dout", {24'h0, dout}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_rdy", {31'h0, rdy}, 32'h0);
    @(posedge CLK); #1;

    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].exp_dout);

    // Strobe and address/data changes while busy must be dropped, not queued.
    addr = 16'h0050; din = 8'h11; nWr = 1'b0;
    sb.push_back('{is_rd: 0, data: 8'hA5, due: cycle + WAIT_T + 2});
    @(posedge CLK); #1;
    addr = 16'h0030; din = 8'hFF; nWr = 1'b0;
    @(posedge CLK); #1;
    nWr = 1'b1; addr = 16'h0000; din = 8'h00;
    repeat (WAIT_T + 4) @(posedge CLK);
    #1;
    checkOutput("ignored_drained", sb.size(), 0);
    applyStimulus(0, 1, 16'h0030, 8'h00, 8'h00);
    applyStimulus(0, 1, 16'h0050, 8'h00, 8'h11);

    // Reset one cycle into a write: commit must be dropped, outputs clear at once.
    addr = 16'h0040; din = 8'h99; nWr = 1'b0;
    @(posedge CLK); #1;
    nWr = 1'b1;
    @(posedge CLK); #3;
    nCLR = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_rst_dout", {24'h0, dout}, 32'h0);
    checkOutput("async_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("async_rst_rdy", {31'h0, rdy}, 32'h0);
    @(posedge CLK); #1;
    nCLR = 1'b1;
    checkOutput("rst_idle_busy", {31'h0, busy}, 32'h0);
    @(posedge CLK); #1;
    applyStimulus(0, 1, 16'h0040, 8'h00, 8'h00);

    // Held nRd re-triggers every WAIT+3 cycles.
    addr = 16'h0010; nRd = 1'b0;
    sb.push_back('{is_rd: 1, data: 8'hA5, due: cycle + WAIT_T + 2});
    sb.push_back('{is_rd: 1, data: 8'hA5, due: cycle + 2 * WAIT_T + 5});
    repeat (WAIT_T + 4) @(posedge CLK);
    #1;
    nRd = 1'b1;
    repeat (WAIT_T + 3) @(posedge CLK);
    #1;
    checkOutput("b2b_drained", sb.size(), 0);

    // Zero wait states and a non-power-of-two depth of 200.
    op2(1, 16'h00D0, 8'hC4, v2, nb2, r2);
    checkOutput("w0_busy_len", nb2, 1);
    checkOutput("w0_rdy", {31'h0, r2}, 32'h1);
    op2(0, 16'h0008, 8'h00, v2, nb2, r2);
    checkOutput("w0_wrap_rd", {24'h0, v2}, 32'hC4);
    checkOutput("w0_rd_rdy", {31'h0, r2}, 32'h1);
    op2(0, 16'h0198, 8'h00, v2, nb2, r2);
    checkOutput("w0_wrap2_rd", {24'h0, v2}, 32'hC4);
    op2(1, 16'h00C7, 8'h2D, v2, nb2, r2);
    op2(1, 16'h0000, 8'hE1, v2, nb2, r2);
    checkOutput("w0_wr_hold", {24'h0, v2}, 32'hC4);
    op2(0, 16'h00C7, 8'h00, v2, nb2, r2);
    checkOutput("w0_top_rd", {24'h0, v2}, 32'h2D);
    op2(0, 16'h00C8, 8'h00, v2, nb2, r2);
    checkOutput("w0_depth_rd", {24'h0, v2}, 32'hE1);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      guard++;
      @(posedge CLK); #1;
    end
    checkOutput("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
